// File: rtl/alu_operand_stage.sv
// ALU operand-select stage: resolves DATA0/DATA1/STORE_DATA per opcode and holds them in a
// 2-entry skid buffer. Define OPSTAGE_FWD_EN to enable EX/MEM result forwarding on r1/r2.
module alu_operand_stage #(
    parameter int unsigned XLEN = 32  // must be >= 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [4:0]      rs1_i,
    input  logic [4:0]      rs2_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [31:0]     pc_i,
    input  logic [11:0]     imm12_i,
    input  logic [19:0]     u_imm20_i,
    input  logic            fwd_ex_valid_i,
    input  logic            fwd_mem_valid_i,
    input  logic [4:0]      fwd_ex_rd_i,
    input  logic [4:0]      fwd_mem_rd_i,
    input  logic [XLEN-1:0] fwd_ex_data_i,
    input  logic [XLEN-1:0] fwd_mem_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] data0_o,
    output logic [XLEN-1:0] data1_o,
    output logic [XLEN-1:0] store_data_o,
    output logic [6:0]      out_opcode_o,
    output logic [2:0]      out_funct3_o
);

    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;

    typedef struct packed {
        logic [XLEN-1:0] data0;
        logic [XLEN-1:0] data1;
        logic [XLEN-1:0] store_data;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    logic [XLEN-1:0] r1, r2;
    logic [XLEN-1:0] imm_i, imm_u, pc_ext, shamt, link;
    entry_t          entry_in;

    assign imm_i  = XLEN'($signed(imm12_i));
    assign imm_u  = XLEN'($signed({u_imm20_i, 12'h000}));
    assign pc_ext = XLEN'(pc_i);
    assign shamt  = XLEN'(rs2_i);
    assign link   = XLEN'(32'd4);

`ifdef OPSTAGE_FWD_EN
    always_comb begin
        r1 = rs1_data_i;
        r2 = rs2_data_i;
        if (fwd_ex_valid_i && (fwd_ex_rd_i == rs1_i)) begin
            r1 = fwd_ex_data_i;
        end else if (fwd_mem_valid_i && (fwd_mem_rd_i == rs1_i)) begin
            r1 = fwd_mem_data_i;
        end
        if (fwd_ex_valid_i && (fwd_ex_rd_i == rs2_i)) begin
            r2 = fwd_ex_data_i;
        end else if (fwd_mem_valid_i && (fwd_mem_rd_i == rs2_i)) begin
            r2 = fwd_mem_data_i;
        end
        // x0 always reads zero, even if a producer claims to write it
        if (rs1_i == 5'd0) r1 = '0;
        if (rs2_i == 5'd0) r2 = '0;
    end
`else
    always_comb begin
        r1 = rs1_data_i;
        r2 = rs2_data_i;
        if (rs1_i == 5'd0) r1 = '0;
        if (rs2_i == 5'd0) r2 = '0;
    end

    logic unused_fwd;
    assign unused_fwd = ^{fwd_ex_valid_i, fwd_mem_valid_i, fwd_ex_rd_i, fwd_mem_rd_i,
                          fwd_ex_data_i, fwd_mem_data_i};
`endif

    always_comb begin
        entry_in.data0      = r1;
        entry_in.data1      = r2;
        entry_in.store_data = r2;
        entry_in.opcode     = opcode_i;
        entry_in.funct3     = funct3_i;
        case (opcode_i)
            OpcOpImm: begin
                entry_in.data1 = ((funct3_i == 3'b001) || (funct3_i == 3'b101)) ? shamt : imm_i;
            end
            OpcOp, OpcBranch: entry_in.data1 = r2;
            OpcLoad, OpcStore: entry_in.data1 = imm_i;
            OpcLui: begin
                entry_in.data0 = '0;
                entry_in.data1 = imm_u;
            end
            OpcAuipc: begin
                entry_in.data0 = pc_ext;
                entry_in.data1 = imm_u;
            end
            OpcJal, OpcJalr: begin
                entry_in.data0 = pc_ext;
                entry_in.data1 = link;
            end
            default: entry_in.data1 = r2;
        endcase
    end

    state_e state_q, state_d;
    entry_t main_q, main_d, skid_q, skid_d;
    logic   in_ready_q, in_ready_d;
    logic   accept, drain;

    assign accept = in_valid_i & in_ready_q;
    assign drain  = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_d  = entry_in;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (accept && drain) begin
                        main_d = entry_in;
                    end else if (accept) begin
                        skid_d  = entry_in;
                        state_d = StTwo;
                    end else if (drain) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        in_ready_d = (state_d != StTwo);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    assign in_ready_o   = in_ready_q;
    assign out_valid_o  = (state_q != StEmpty);
    assign data0_o      = main_q.data0;
    assign data1_o      = main_q.data1;
    assign store_data_o = main_q.store_data;
    assign out_opcode_o = main_q.opcode;
    assign out_funct3_o = main_q.funct3;

endmodule
